// File: rtl/jtag_tap_multi.sv
// Parametrised IEEE 1149.1 TAP with internal IDCODE/BYPASS and NumDr external DR channels.
// Define JTAG_TAP_USERCODE_EN to add a 32-bit USERCODE DR decoded at UserCodeIr.
module jtag_tap_multi #(
   parameter int unsigned         IrLength       = 5,
   parameter logic [31:0]         IdCodeValue    = 32'h00000001,
   parameter logic [IrLength-1:0] IrCaptureValue = 'b00101,
   parameter int unsigned         NumDr          = 2,
   parameter int unsigned         DrIrBase       = 'h10,
   parameter logic [31:0]         UserCodeValue  = 32'h00000000,
   parameter int unsigned         UserCodeIr     = 'h1e
) (
   input  logic                tck_i,
   input  logic                trst_ni,
   input  logic                tms_i,
   input  logic                td_i,
   output logic                td_o,
   output logic                tdo_oe_o,
   output logic                tck_o,
   output logic                tdi_o,
   output logic                capture_o,
   output logic                shift_o,
   output logic                update_o,
   output logic                dmi_clear_o,
   output logic [NumDr-1:0]    dr_select_o,
   input  logic [NumDr-1:0]    dr_tdo_i,
   output logic [IrLength-1:0] ir_o,
   output logic [3:0]          tap_state_o
);

   typedef enum logic [3:0] {
      TestLogicReset = 4'd0,  RunTestIdle = 4'd1,  SelectDrScan = 4'd2,  CaptureDr = 4'd3,
      ShiftDr        = 4'd4,  Exit1Dr     = 4'd5,  PauseDr      = 4'd6,  Exit2Dr   = 4'd7,
      UpdateDr       = 4'd8,  SelectIrScan = 4'd9, CaptureIr    = 4'd10, ShiftIr   = 4'd11,
      Exit1Ir        = 4'd12, PauseIr     = 4'd13, Exit2Ir      = 4'd14, UpdateIr  = 4'd15
   } tap_state_e;

   localparam logic [IrLength-1:0] IrIdcode  = IrLength'(1);
   localparam logic [IrLength-1:0] IrCapture = (IrCaptureValue & ~IrLength'(3)) | IrLength'(1);
   localparam int unsigned         IrAllOnes = (1 << IrLength) - 1;

   if (IrLength < 2 || IrLength > 8) begin : g_err_irlen
      $error("jtag_tap_multi: IrLength out of range 2..8");
   end
   if (NumDr < 1 || NumDr > 8) begin : g_err_numdr
      $error("jtag_tap_multi: NumDr out of range 1..8");
   end
   if (IdCodeValue[0] != 1'b1) begin : g_err_idcode
      $error("jtag_tap_multi: IdCodeValue bit 0 must be 1");
   end
   for (genvar i = 0; i < NumDr; i++) begin : g_chk
      localparam int unsigned Code = DrIrBase + i;
      if (Code == 0 || Code == 1 || Code >= IrAllOnes) begin : g_err_rsvd
         $error("jtag_tap_multi: external DR code collides with reserved code or overflows IR");
      end
`ifdef JTAG_TAP_USERCODE_EN
      if (Code == UserCodeIr) begin : g_err_user
         $error("jtag_tap_multi: external DR code collides with UserCodeIr");
      end
`endif
   end

   tap_state_e             state_q, state_d;
   logic [IrLength-1:0]    ir_q, ir_sr_q;
   logic [31:0]            idcode_q;
   logic                   bypass_q;
   logic [NumDr-1:0]       dr_sel;
   logic                   idcode_sel, bypass_sel, tdo_mux, tlr;

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) state_q <= TestLogicReset;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
         RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
         SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
         CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
         ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
         Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
         PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
         Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
         UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
         SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
         CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
         ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
         Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
         PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
         Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
         UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
         default:        state_d = TestLogicReset;
      endcase
   end

   // Registers are cleared on the edge that lands in TestLogicReset as well as while
   // sitting there, so decode is already clean the first cycle the TAP is in reset.
   assign tlr = (state_q == TestLogicReset) || (state_d == TestLogicReset);

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         ir_q    <= IrIdcode;
         ir_sr_q <= '0;
      end else if (tlr) begin
         ir_q    <= IrIdcode;
         ir_sr_q <= '0;
      end else begin
         case (state_q)
            CaptureIr: ir_sr_q <= IrCapture;
            ShiftIr:   ir_sr_q <= {td_i, ir_sr_q[IrLength-1:1]};
            UpdateIr:  ir_q    <= ir_sr_q;
            default: ;
         endcase
      end
   end

   always_comb begin
      dr_sel = '0;
      for (int unsigned i = 0; i < NumDr; i++)
         if (ir_q == IrLength'(DrIrBase + i)) dr_sel[i] = 1'b1;
   end

   assign idcode_sel = (ir_q == IrIdcode);

`ifdef JTAG_TAP_USERCODE_EN
   logic        usercode_sel;
   logic [31:0] usercode_q;
   assign usercode_sel = (ir_q == IrLength'(UserCodeIr));
   assign bypass_sel   = !idcode_sel && !usercode_sel && !(|dr_sel);

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni)                                   usercode_q <= UserCodeValue;
      else if (tlr)                                   usercode_q <= UserCodeValue;
      else if (usercode_sel && state_q == CaptureDr)  usercode_q <= UserCodeValue;
      else if (usercode_sel && state_q == ShiftDr)    usercode_q <= {td_i, usercode_q[31:1]};
   end
`else
   logic unused_usercode;
   assign unused_usercode = ^{UserCodeValue, 32'(UserCodeIr)};
   assign bypass_sel      = !idcode_sel && !(|dr_sel);
`endif

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         idcode_q <= IdCodeValue;
         bypass_q <= 1'b0;
      end else if (tlr) begin
         idcode_q <= IdCodeValue;
         bypass_q <= 1'b0;
      end else begin
         if (idcode_sel && state_q == CaptureDr) idcode_q <= IdCodeValue;
         if (idcode_sel && state_q == ShiftDr)   idcode_q <= {td_i, idcode_q[31:1]};
         if (bypass_sel && state_q == CaptureDr) bypass_q <= 1'b0;
         if (bypass_sel && state_q == ShiftDr)   bypass_q <= td_i;
      end
   end

   always_comb begin
      tdo_mux = bypass_q;
      if (state_q == ShiftIr)  tdo_mux = ir_sr_q[0];
      else if (idcode_sel)     tdo_mux = idcode_q[0];
`ifdef JTAG_TAP_USERCODE_EN
      else if (usercode_sel)   tdo_mux = usercode_q[0];
`endif
      else if (|dr_sel)        tdo_mux = |(dr_sel & dr_tdo_i);
   end

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         td_o     <= 1'b0;
         tdo_oe_o <= 1'b0;
      end else begin
         td_o     <= tdo_mux;
         tdo_oe_o <= (state_q == ShiftIr) || (state_q == ShiftDr);
      end
   end

   assign tck_o       = tck_i;
   assign tdi_o       = td_i;
   assign capture_o   = (state_q == CaptureDr);
   assign shift_o     = (state_q == ShiftDr);
   assign update_o    = (state_q == UpdateDr);
   assign dmi_clear_o = (state_q == TestLogicReset);
   assign dr_select_o = dr_sel;
   assign ir_o        = ir_q;
   assign tap_state_o = state_q;

endmodule
